// File: rtl/aes_pkg.sv
// Shared definitions for the AES decipher front-end: controller states,
// key-length encodings and the default completion watchdog.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LOW,
        WAIT_DONE,
        RESP
    } state_t;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    localparam int WDOG_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/aes_dec_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/aes_dec_arbiter.sv
// Shares one AES decipher core between two request/response channel pairs,
// with round-robin arbitration and a watchdog on core completion.
module aes_dec_arbiter
    import aes_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_block,
    input  logic         req0_keylen,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_block,
    input  logic         req1_keylen,

    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [127:0] rsp0_block,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp1_block,
    output logic         rsp1_err,

    output logic         core_next,
    output logic         core_keylen,
    output logic [127:0] core_block,
    output logic         core_key_sel,
    input  logic         core_ready,
    input  logic [127:0] core_new_block,

    output logic         busy
);

    localparam int WDW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    state_t         state;
    logic           last;
    logic [WDW-1:0] wdog;
    logic [127:0]   rsp_block;
    logic [1:0]     gnt;
    logic           accept;
    logic           done;
    logic           timeout;

    rr_arb2 u_arb (
        .req  ({req1_valid, req0_valid}),
        .last (last),
        .gnt  (gnt)
    );

    // Ready is a direct view of the grant so a withdrawn request is never taken.
    assign req0_ready = reset_n && (state == IDLE) && core_ready && gnt[0];
    assign req1_ready = reset_n && (state == IDLE) && core_ready && gnt[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign done    = (state == WAIT_DONE) && core_ready;
    assign timeout = ((state == WAIT_LOW) || (state == WAIT_DONE)) && !done
                     && (wdog == WDW'(WDOG_CYCLES - 1));

    assign rsp0_block = rsp_block;
    assign rsp1_block = rsp_block;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            last         <= 1'b1;
            wdog         <= '0;
            core_next    <= 1'b0;
            core_block   <= '0;
            core_keylen  <= AES_128_BIT_KEY;
            core_key_sel <= 1'b0;
            rsp_block    <= '0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_err     <= 1'b0;
            rsp1_err     <= 1'b0;
        end else begin
            core_next <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        core_block   <= gnt[1] ? req1_block  : req0_block;
                        core_keylen  <= gnt[1] ? req1_keylen : req0_keylen;
                        core_key_sel <= gnt[1];
                        last         <= gnt[1];
                        core_next    <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wdog  <= '0;
                    state <= WAIT_LOW;
                end
                WAIT_LOW, WAIT_DONE: begin
                    // A completion seen on the last watchdog cycle still wins.
                    if (done || timeout) begin
                        rsp_block  <= done ? core_new_block : '0;
                        rsp0_valid <= !core_key_sel;
                        rsp1_valid <= core_key_sel;
                        rsp0_err   <= !core_key_sel && timeout;
                        rsp1_err   <= core_key_sel && timeout;
                        state      <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (state == WAIT_LOW && !core_ready) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                RESP: begin
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        rsp0_err   <= 1'b0;
                        rsp1_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Bench for aes_dec_arbiter: a behavioural decipher core with programmable
// latency, directed FIPS-197 cases and randomized request traffic.
module tb_aes_dec_arbiter;

    localparam int WDOG = 8;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_block = '0, req1_block = '0;
    logic         req0_keylen = 1'b0, req1_keylen = 1'b0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [127:0] rsp0_block, rsp1_block;
    logic         rsp0_err, rsp1_err;
    logic         core_next, core_keylen, core_key_sel;
    logic [127:0] core_block;
    logic         core_ready;
    logic [127:0] core_new_block;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int core_lat = 2;
    bit stuck = 1'b0;
    int next_pulses = 0;

    aes_dec_arbiter #(.WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block), .req0_keylen(req0_keylen),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block), .req1_keylen(req1_keylen),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_block(rsp0_block), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_block(rsp1_block), .rsp1_err(rsp1_err),
        .core_next(core_next), .core_keylen(core_keylen), .core_block(core_block), .core_key_sel(core_key_sel),
        .core_ready(core_ready), .core_new_block(core_new_block), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in decipher: the FIPS-197 vectors under the matching key schedule,
    // otherwise a reversible scramble that depends on key length and schedule.
    function automatic logic [127:0] core_fn(input logic [127:0] b, input logic kl, input logic sel);
        if (!kl && !sel && b == CT128) return PT;
        if (kl && sel && b == CT256) return PT;
        return b ^ {4{32'hA5C3_0F1E}} ^ (kl ? {4{32'h1357_9BDF}} : 128'h0)
                 ^ (sel ? {4{32'h0F0F_F0F0}} : 128'h0);
    endfunction

    int           lat_left = 0;
    bit           c_busy = 1'b0;
    logic [127:0] c_blk = '0;
    logic         c_kl = 1'b0, c_sel = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            core_ready     <= 1'b1;
            core_new_block <= '0;
            c_busy         <= 1'b0;
            lat_left       <= 0;
        end else if (c_busy) begin
            if (lat_left == 0) begin
                core_ready     <= 1'b1;
                core_new_block <= core_fn(c_blk, c_kl, c_sel);
                c_busy         <= 1'b0;
            end else begin
                lat_left <= lat_left - 1;
            end
        end else if (core_next && !stuck) begin
            core_ready <= 1'b0;
            c_busy     <= 1'b1;
            lat_left   <= core_lat;
            c_blk      <= core_block;
            c_kl       <= core_keylen;
            c_sel      <= core_key_sel;
        end
    end

    always @(negedge clk) begin
        if (reset_n && core_next) next_pulses <= next_pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int n, input logic v, input logic [127:0] b, input logic kl);
        if (n == 0) begin
            req0_valid = v; req0_block = b; req0_keylen = kl;
        end else begin
            req1_valid = v; req1_block = b; req1_keylen = kl;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One transaction on channel n; returns observations, checks are done by callers.
    task automatic run_one(input int n, input logic [127:0] blk, input logic kl, input int hold,
                           output logic [127:0] rblk, output logic rerr, output int pulses,
                           output int wait_cyc, output bit timed_out, output bit side_ok);
        int   p0;
        bit   acc;
        logic sel;
        sel = n[0];
        side_ok = 1'b1; timed_out = 1'b0; acc = 1'b0; wait_cyc = 0;
        rblk = '0; rerr = 1'b0; pulses = 0;
        drive_req(n, 1'b1, blk, kl);
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            acc = (n == 0) ? req0_ready : req1_ready;
            cyc();
        end
        drive_req(n, 1'b0, '0, 1'b0);
        if (!acc) begin
            timed_out = 1'b1;
            return;
        end
        p0 = next_pulses;
        while (!(rsp0_valid || rsp1_valid) && wait_cyc < 60) begin
            if (core_block !== blk || core_keylen !== kl || core_key_sel !== sel) side_ok = 1'b0;
            cyc();
            wait_cyc++;
        end
        if (!(rsp0_valid || rsp1_valid)) begin
            timed_out = 1'b1;
            return;
        end
        rblk = sel ? rsp1_block : rsp0_block;
        rerr = sel ? rsp1_err : rsp0_err;
        if ((sel ? rsp0_valid : rsp1_valid) !== 1'b0 || (sel ? rsp1_valid : rsp0_valid) !== 1'b1)
            side_ok = 1'b0;
        for (int i = 0; i < hold; i++) begin
            drive_req(1 - n, 1'b1, rnd128(), 1'b0);
            #1;
            if (((n == 0) ? req1_ready : req0_ready) !== 1'b0 || busy !== 1'b1) side_ok = 1'b0;
            cyc();
            if ((sel ? rsp1_block : rsp0_block) !== rblk || (sel ? rsp1_valid : rsp0_valid) !== 1'b1
                || (sel ? rsp0_valid : rsp1_valid) !== 1'b0 || (sel ? rsp1_err : rsp0_err) !== rerr
                || core_block !== blk || core_keylen !== kl || core_key_sel !== sel)
                side_ok = 1'b0;
        end
        drive_req(1 - n, 1'b0, '0, 1'b0);
        if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        if (rsp0_valid || rsp1_valid) side_ok = 1'b0;
        pulses = next_pulses - p0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_block = rnd128(); req1_block = rnd128();
        repeat (3) cyc();
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++;
            $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready); end
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++;
            $display("FAIL reset_rsp_valid: got %b%b want 00", rsp1_valid, rsp0_valid); end
        checks++; if (rsp0_err !== 1'b0 || rsp1_err !== 1'b0) begin failures++;
            $display("FAIL reset_rsp_err: got %b%b want 00", rsp1_err, rsp0_err); end
        checks++; if (core_next !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL reset_next_busy: got next=%b busy=%b want 0 0", core_next, busy); end
        checks++; if (core_block !== '0 || rsp0_block !== '0 || rsp1_block !== '0) begin failures++;
            $display("FAIL reset_blocks: got core=%h rsp0=%h want 0", core_block, rsp0_block); end
        checks++; if (core_keylen !== 1'b0 || core_key_sel !== 1'b0) begin failures++;
            $display("FAIL reset_keylen_sel: got %b %b want 0 0", core_keylen, core_key_sel); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_fips128();
        logic [127:0] rb; logic re; int pu, wc; bit to, ok;
        core_lat = 3;
        run_one(0, CT128, 1'b0, 0, rb, re, pu, wc, to, ok);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL fips128_timeout: got 1 want 0"); end
        checks++; if (rb !== PT) begin failures++; $display("FAIL fips128_block: got %h want %h", rb, PT); end
        checks++; if (re !== 1'b0) begin failures++; $display("FAIL fips128_err: got %b want 0", re); end
        checks++; if (pu !== 1) begin failures++; $display("FAIL fips128_next_pulses: got %0d want 1", pu); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fips128_channel_hold: got 0 want 1"); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fips128_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_aes256();
        logic [127:0] rb; logic re; int pu, wc; bit to, ok;
        core_lat = 4;
        run_one(1, CT256, 1'b1, 2, rb, re, pu, wc, to, ok);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL aes256_timeout: got 1 want 0"); end
        checks++; if (rb !== PT) begin failures++; $display("FAIL aes256_block: got %h want %h", rb, PT); end
        checks++; if (re !== 1'b0) begin failures++; $display("FAIL aes256_err: got %b want 0", re); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL aes256_keylen_sel_hold: got 0 want 1"); end
    endtask

    task automatic test_backpressure();
        logic [127:0] rb, b; logic re, kl; int pu, wc, p_after; bit to, ok;
        b = rnd128(); kl = 1'($urandom_range(0, 1)); core_lat = 1;
        run_one(1, b, kl, 20, rb, re, pu, wc, to, ok);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout: got 1 want 0"); end
        checks++; if (rb !== core_fn(b, kl, 1'b1)) begin failures++;
            $display("FAIL bp_block: got %h want %h", rb, core_fn(b, kl, 1'b1)); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_stable_busy_ready: got 0 want 1"); end
        p_after = next_pulses;
        repeat (5) cyc();
        checks++; if (busy !== 1'b0 || next_pulses !== p_after) begin failures++;
            $display("FAIL bp_withdrawn_req: got busy=%b launches=%0d want 0 0", busy, next_pulses - p_after); end
    endtask

    task automatic test_contention();
        logic [127:0] b0, b1, exp_b, got_b; logic k0, k1;
        int exp_g, g, own, resp, granted;
        b0 = rnd128(); b1 = rnd128();
        k0 = 1'($urandom_range(0, 1)); k1 = 1'($urandom_range(0, 1));
        core_lat = $urandom_range(0, 4);
        reset_n = 1'b0;
        drive_req(0, 1'b1, b0, k0); drive_req(1, 1'b1, b1, k1);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) cyc();
        reset_n = 1'b1;
        exp_g = 0; own = 0; resp = 0; granted = 0;
        for (int c = 0; c < 300 && resp < 4; c++) begin
            #1;
            checks++; if (req0_ready && req1_ready) begin failures++;
                $display("FAIL cont_one_hot_ready: got 11 want at most one"); end
            if (req0_ready || req1_ready) begin
                g = req1_ready ? 1 : 0;
                checks++; if (g != exp_g) begin failures++;
                    $display("FAIL cont_grant_order: grant %0d got %0d want %0d", granted, g, exp_g); end
                exp_g = 1 - g; own = g; granted++;
            end
            if (rsp0_valid || rsp1_valid) begin
                checks++;
                if ((own == 0 ? rsp0_valid : rsp1_valid) !== 1'b1 || (own == 0 ? rsp1_valid : rsp0_valid) !== 1'b0) begin
                    failures++;
                    $display("FAIL cont_rsp_channel: got %b%b want owner %0d only", rsp1_valid, rsp0_valid, own);
                end
                exp_b = (own == 0) ? core_fn(b0, k0, 1'b0) : core_fn(b1, k1, 1'b1);
                got_b = (own == 0) ? rsp0_block : rsp1_block;
                checks++; if (got_b !== exp_b) begin failures++;
                    $display("FAIL cont_rsp_block: got %h want %h", got_b, exp_b); end
                resp++;
                if (resp == 4) begin
                    drive_req(0, 1'b0, '0, 1'b0); drive_req(1, 1'b0, '0, 1'b0);
                end
            end
            cyc();
        end
        drive_req(0, 1'b0, '0, 1'b0); drive_req(1, 1'b0, '0, 1'b0);
        checks++; if (resp != 4) begin failures++; $display("FAIL cont_responses: got %0d want 4", resp); end
        cyc();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_watchdog();
        logic [127:0] rb; logic re; int pu, wc; bit to, ok;
        stuck = 1'b1;
        run_one(0, rnd128(), 1'b0, 0, rb, re, pu, wc, to, ok);
        stuck = 1'b0;
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL wdog_no_response: got timeout want response"); end
        checks++; if (re !== 1'b1) begin failures++; $display("FAIL wdog_err: got %b want 1", re); end
        checks++; if (rb !== '0) begin failures++; $display("FAIL wdog_block: got %h want 0", rb); end
        checks++; if (wc < WDOG || wc > WDOG + 2) begin failures++;
            $display("FAIL wdog_latency: got %0d want %0d..%0d", wc, WDOG, WDOG + 2); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wdog_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit acc; bit seen;
        core_lat = 5; acc = 1'b0; seen = 1'b0;
        drive_req(0, 1'b1, rnd128(), 1'b0);
        for (int i = 0; i < 20 && !acc; i++) begin
            #1; acc = req0_ready; cyc();
        end
        drive_req(0, 1'b0, '0, 1'b0);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL rmid_accept: got 0 want 1"); end
        cyc(); cyc();
        checks++; if (busy !== 1'b1 || core_ready !== 1'b0) begin failures++;
            $display("FAIL rmid_in_flight: got busy=%b core_ready=%b want 1 0", busy, core_ready); end
        reset_n = 1'b0;
        req0_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) begin
            cyc();
            if (rsp0_valid || rsp1_valid) seen = 1'b1;
        end
        reset_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || req0_ready !== 1'b1) begin failures++;
            $display("FAIL rmid_release: got busy=%b req0_ready=%b want 0 1", busy, req0_ready); end
        req0_valid = 1'b0;
        repeat (10) begin
            cyc();
            if (rsp0_valid || rsp1_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rmid_no_response: got rsp_valid want none"); end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] rb, b; logic re, kl; int n, pu, wc; bit to, ok;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 1); b = rnd128(); kl = 1'($urandom_range(0, 1));
            core_lat = $urandom_range(0, 4);
            run_one(n, b, kl, $urandom_range(0, 3), rb, re, pu, wc, to, ok);
            checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand_timeout: iter %0d got timeout", it); end
            checks++; if (rb !== core_fn(b, kl, n[0])) begin failures++;
                $display("FAIL rand_block: iter %0d got %h want %h", it, rb, core_fn(b, kl, n[0])); end
            checks++; if (re !== 1'b0 || pu !== 1) begin failures++;
                $display("FAIL rand_err_pulses: iter %0d got err=%b pulses=%0d want 0 1", it, re, pu); end
            checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rand_channel_hold: iter %0d got 0 want 1", it); end
        end
    endtask

    initial begin
        test_reset();
        test_fips128();
        test_aes256();
        test_backpressure();
        test_contention();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
